// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped I/O bus: region nibbles, device
// window offsets, keyboard control bit positions and small decode helpers.
package mmio_pkg;

  // Region selectors taken from addr[31:28]
  localparam logic [3:0] REG_RAM  = 4'h0;
  localparam logic [3:0] REG_VRAM = 4'h1;
  localparam logic [3:0] REG_ROM  = 4'h2;
  localparam logic [3:0] REG_DEV  = 4'hF;

  // Offsets inside the device window (addr[27:0])
  localparam logic [27:0] OFF_SWITCH     = 28'h000_0000;
  localparam logic [27:0] OFF_KBD_STATUS = 28'h000_0004;
  localparam logic [27:0] OFF_KBD_DATA   = 28'h000_0008;
  localparam logic [27:0] OFF_KBD_CTRL   = 28'h000_000C;
  localparam logic [27:0] OFF_OUT_BASE   = 28'h000_0040;

  // KBD_CTRL bit positions
  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_OVF_CLR = 2;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_VRAM,
    RGN_ROM,
    RGN_DEV,
    RGN_NONE
  } region_e;

  function automatic region_e decode_region(input logic [3:0] nib);
    region_e r;
    case (nib)
      REG_RAM:  r = RGN_RAM;
      REG_VRAM: r = RGN_VRAM;
      REG_ROM:  r = RGN_ROM;
      REG_DEV:  r = RGN_DEV;
      default:  r = RGN_NONE;
    endcase
    return r;
  endfunction

  // Layout of the KBD_STATUS word
  function automatic logic [31:0] kbd_status_word(input logic [7:0] cnt,
                                                  input logic       ovf,
                                                  input logic       full,
                                                  input logic       empty);
    return {16'h0000, cnt, 5'b00000, ovf, full, empty};
  endfunction

endpackage

// File: rtl/mmio_io_bus_kbd_fifo.sv
// First-word-fall-through scancode FIFO. The head entry is visible without a
// read strobe; a pop just advances the read pointer. A push while full is
// accepted only when a pop happens in the same cycle. Flush beats everything.
module kbd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [7:0]                 head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_COUNT);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage write; entries need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mmio_io_bus.sv
// Memory-mapped I/O bus: combinational region decode towards cache, VRAM and
// ROM, plus a registered device window holding switches, a keyboard FIFO with
// status/overflow/irq control, and a bank of CPU-writable output registers.
module mmio_io_bus
  import mmio_pkg::*;
#(
  parameter int NUM_OUT_REGS = 4,
  parameter int KBD_DEPTH    = 8,
  parameter int SW_W         = 16,
  parameter int VRAM_AW      = 19,
  parameter int VRAM_DW      = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               addr4CPU,
  input  logic                      re4CPU,
  input  logic                      we4CPU,
  input  logic [31:0]               data4CPU,
  output logic [31:0]               data2CPU,
  output logic [31:0]               addr2Cache,
  output logic [31:0]               data2Cache,
  output logic                      re2Cache,
  output logic                      we2Cache,
  input  logic [31:0]               data4Cache,
  output logic [VRAM_AW-1:0]        addr2VRAM,
  output logic                      we2VRAM,
  output logic [VRAM_DW-1:0]        data2VRAM,
  input  logic [VRAM_DW-1:0]        data4VRAM,
  output logic [31:0]               addr2ROM,
  input  logic [31:0]               data4ROM,
  input  logic [SW_W-1:0]           switch,
  output logic [32*NUM_OUT_REGS-1:0] out_regs,
  input  logic                      kbd_valid,
  input  logic [7:0]                kbd_code,
  output logic                      kbd_irq
);

  localparam int CW = $clog2(KBD_DEPTH) + 1;

  region_e     region;
  logic [27:0] offset;
  logic        dev_sel;

  assign region  = decode_region(addr4CPU[31:28]);
  assign offset  = addr4CPU[27:0];
  assign dev_sel = (region == RGN_DEV);

  // Pass-through ports; only the strobes are region-qualified
  assign addr2Cache = addr4CPU;
  assign data2Cache = data4CPU;
  assign re2Cache   = re4CPU & (region == RGN_RAM);
  assign we2Cache   = we4CPU & (region == RGN_RAM);
  assign addr2VRAM  = addr4CPU[VRAM_AW+1:2];
  assign data2VRAM  = data4CPU[VRAM_DW-1:0];
  assign we2VRAM    = we4CPU & (region == RGN_VRAM);
  assign addr2ROM   = addr4CPU;

  // Device window decode; OUT slots must be word aligned and exist
  logic       hit_switch, hit_status, hit_data, hit_ctrl, hit_out;
  logic [3:0] out_idx;

  assign hit_switch = dev_sel && (offset == OFF_SWITCH);
  assign hit_status = dev_sel && (offset == OFF_KBD_STATUS);
  assign hit_data   = dev_sel && (offset == OFF_KBD_DATA);
  assign hit_ctrl   = dev_sel && (offset == OFF_KBD_CTRL);
  assign out_idx    = offset[5:2];
  assign hit_out    = dev_sel && (offset[27:6] == OFF_OUT_BASE[27:6]) &&
                      (offset[1:0] == 2'b00) &&
                      ({1'b0, out_idx} < 5'(NUM_OUT_REGS));

  // Keyboard FIFO control
  logic          ctrl_wr, fifo_flush, ovf_clr, pop_req, pop_eff, ovf_set;
  logic [7:0]    fifo_head;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  logic          irq_en_reg;
  logic          ovf_reg, ovf_next;
  logic [SW_W-1:0] sw_meta_reg, sw_sync_reg;

  assign ctrl_wr    = we4CPU & hit_ctrl;
  assign fifo_flush = ctrl_wr & data4CPU[CTRL_FLUSH];
  assign ovf_clr    = ctrl_wr & data4CPU[CTRL_OVF_CLR];
  assign pop_req    = re4CPU & hit_data;
  assign pop_eff    = pop_req & ~fifo_empty;
  // A full push is only lost when nothing leaves and no flush discards it anyway
  assign ovf_set    = kbd_valid & fifo_full & ~pop_eff & ~fifo_flush;

  kbd_fifo #(
    .DEPTH (KBD_DEPTH)
  ) u_kbd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (kbd_valid),
    .wdata (kbd_code),
    .pop   (pop_req),
    .flush (fifo_flush),
    .head  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Sticky overflow: a new overflow outranks a simultaneous clear
  always_comb begin
    ovf_next = ovf_reg;
    if (ovf_set)      ovf_next = 1'b1;
    else if (ovf_clr) ovf_next = 1'b0;
  end

  // Keyboard control state and overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en_reg <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_reg <= data4CPU[CTRL_IRQ_EN];
      ovf_reg <= ovf_next;
    end
  end

  // Two-flop synchroniser for the asynchronous switch inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      sw_meta_reg <= switch;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  assign kbd_irq = irq_en_reg & ~fifo_empty;

  // Output register bank, one 32-bit slot per generate instance
  for (genvar gi = 0; gi < NUM_OUT_REGS; gi++) begin : g_out
    logic [31:0] slot_reg;

    // Slot write on an aligned CPU store to this slot's address
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        slot_reg <= '0;
      end else if (we4CPU && hit_out && (out_idx == 4'(gi))) begin
        slot_reg <= data4CPU;
      end
    end

    assign out_regs[32*gi +: 32] = slot_reg;
  end

  // Combinational read-data mux across regions and device registers
  always_comb begin
    data2CPU = '0;
    case (region)
      RGN_RAM:  data2CPU = data4Cache;
      RGN_VRAM: data2CPU = 32'(data4VRAM);
      RGN_ROM:  data2CPU = data4ROM;
      RGN_DEV: begin
        if (hit_switch) data2CPU = 32'(sw_sync_reg);
        if (hit_status) data2CPU = kbd_status_word(8'(fifo_count), ovf_reg,
                                                   fifo_full, fifo_empty);
        if (hit_data)   data2CPU = fifo_empty ? 32'h0 : {24'h0, fifo_head};
        if (hit_ctrl)   data2CPU = {31'h0, irq_en_reg};
        if (hit_out) begin
          for (int i = 0; i < NUM_OUT_REGS; i++) begin
            if (out_idx == 4'(i)) data2CPU = out_regs[32*i +: 32];
          end
        end
      end
      default: data2CPU = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_io_bus.sv
// Self-checking bench for mmio_io_bus: keyboard codes are pushed into a
// scoreboard queue when driven and popped when the CPU reads KBD_DATA.
module tb_mmio_io_bus;

  localparam int NUM_OUT = 4;
  localparam int DEPTH   = 8;
  localparam int SW_W    = 16;
  localparam int VAW     = 19;
  localparam int VDW     = 12;

  localparam logic [31:0] A_SWITCH = 32'hF000_0000;
  localparam logic [31:0] A_STATUS = 32'hF000_0004;
  localparam logic [31:0] A_DATA   = 32'hF000_0008;
  localparam logic [31:0] A_CTRL   = 32'hF000_000C;
  localparam logic [31:0] A_OUT0   = 32'hF000_0040;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [31:0]             addr4CPU;
  logic                    re4CPU, we4CPU;
  logic [31:0]             data4CPU, data2CPU;
  logic [31:0]             addr2Cache, data2Cache, data4Cache;
  logic                    re2Cache, we2Cache;
  logic [VAW-1:0]          addr2VRAM;
  logic                    we2VRAM;
  logic [VDW-1:0]          data2VRAM, data4VRAM;
  logic [31:0]             addr2ROM, data4ROM;
  logic [SW_W-1:0]         switch;
  logic [32*NUM_OUT-1:0]   out_regs;
  logic                    kbd_valid;
  logic [7:0]              kbd_code;
  logic                    kbd_irq;

  mmio_io_bus #(
    .NUM_OUT_REGS (NUM_OUT),
    .KBD_DEPTH    (DEPTH),
    .SW_W         (SW_W),
    .VRAM_AW      (VAW),
    .VRAM_DW      (VDW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr4CPU   (addr4CPU),
    .re4CPU     (re4CPU),
    .we4CPU     (we4CPU),
    .data4CPU   (data4CPU),
    .data2CPU   (data2CPU),
    .addr2Cache (addr2Cache),
    .data2Cache (data2Cache),
    .re2Cache   (re2Cache),
    .we2Cache   (we2Cache),
    .data4Cache (data4Cache),
    .addr2VRAM  (addr2VRAM),
    .we2VRAM    (we2VRAM),
    .data2VRAM  (data2VRAM),
    .data4VRAM  (data4VRAM),
    .addr2ROM   (addr2ROM),
    .data4ROM   (data4ROM),
    .switch     (switch),
    .out_regs   (out_regs),
    .kbd_valid  (kbd_valid),
    .kbd_code   (kbd_code),
    .kbd_irq    (kbd_irq)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  sb_q[$];
  logic        m_ovf = 1'b0;
  logic [31:0] m_out [NUM_OUT];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {16'h0, 8'(sb_q.size()), 5'h0, m_ovf,
            sb_q.size() == DEPTH, sb_q.size() == 0};
  endfunction

  // All tasks start and end one time unit after a rising edge
  task automatic cpu_rd(input logic [31:0] a, output logic [31:0] d);
    addr4CPU = a;
    re4CPU   = 1'b1;
    @(negedge clk);
    d = data2CPU;
    @(posedge clk);
    #1;
    re4CPU   = 1'b0;
    addr4CPU = '0;
    $display("rd  addr=%08h data=%08h", a, d);
  endtask

  task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
    addr4CPU = a;
    data4CPU = d;
    we4CPU   = 1'b1;
    @(posedge clk);
    #1;
    we4CPU   = 1'b0;
    addr4CPU = '0;
    $display("wr  addr=%08h data=%08h", a, d);
  endtask

  task automatic kbd_push(input logic [7:0] c);
    kbd_valid = 1'b1;
    kbd_code  = c;
    @(posedge clk);
    #1;
    kbd_valid = 1'b0;
    if (sb_q.size() < DEPTH) sb_q.push_back(c);
    else                     m_ovf = 1'b1;
    $display("kbd push code=%02h depth=%0d", c, sb_q.size());
  endtask

  task automatic kbd_read(input string tag, output logic [7:0] got);
    logic [31:0] d;
    logic [31:0] e;
    cpu_rd(A_DATA, d);
    e = '0;
    if (sb_q.size() > 0) e = {24'h0, sb_q.pop_front()};
    check(tag, d, e);
    got = d[7:0];
  endtask

  task automatic status_chk(input string tag, input logic [31:0] lit);
    logic [31:0] d;
    cpu_rd(A_STATUS, d);
    check(tag, d, lit);
    check({tag, "_model"}, d, exp_status());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  c;

    rst = 1'b0; addr4CPU = '0; re4CPU = 1'b0; we4CPU = 1'b0; data4CPU = '0;
    data4Cache = 32'hCAFE_0001; data4VRAM = 12'h5A5; data4ROM = 32'h0BAD_F00D;
    switch = '0; kbd_valid = 1'b0; kbd_code = '0;
    for (int i = 0; i < NUM_OUT; i++) m_out[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NUM_OUT; i++) check("rst_out", out_regs[32*i +: 32], 32'h0);
    check("rst_irq", 32'(kbd_irq), 32'h0);
    addr4CPU = A_STATUS;
    #1;
    check("rst_status", data2CPU, 32'h1);
    addr4CPU = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of traffic
    cpu_wr(A_CTRL, 32'h1);
    kbd_push(8'h11); kbd_push(8'h22); kbd_push(8'h33);
    cpu_wr(A_OUT0, 32'h0000_1234);
    check("pre_rst_out0", out_regs[31:0], 32'h0000_1234);
    check("pre_rst_irq", 32'(kbd_irq), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < NUM_OUT; i++) check("async_rst_out", out_regs[32*i +: 32], 32'h0);
    check("async_rst_irq", 32'(kbd_irq), 32'h0);
    addr4CPU = A_STATUS;
    #1;
    check("async_rst_status", data2CPU, 32'h1);
    rst = 1'b1;
    addr4CPU = '0;
    sb_q.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    cpu_rd(A_CTRL, d);
    check("rst_ctrl", d, 32'h0);

    // Basic FIFO order and empty read
    kbd_push(8'h1C); kbd_push(8'h32); kbd_push(8'h21);
    status_chk("status3", 32'h0000_0300);
    kbd_read("data0", c);
    check("data0_lit", 32'(c), 32'h1C);
    kbd_read("data1", c);
    kbd_read("data2", c);
    check("data2_lit", 32'(c), 32'h21);
    status_chk("status_empty", 32'h0000_0001);
    kbd_read("data_empty", c);
    status_chk("status_empty2", 32'h0000_0001);

    // Fill, overflow, clear, simultaneous push+pop when full
    for (int i = 0; i < DEPTH; i++) kbd_push(8'(8'h40 + i));
    kbd_push(8'hAA);
    status_chk("status_ovf", 32'h0000_0806);
    cpu_wr(A_CTRL, 32'h4);
    m_ovf = 1'b0;
    status_chk("status_ovf_clr", 32'h0000_0802);
    kbd_valid = 1'b1; kbd_code = 8'hBB; addr4CPU = A_DATA; re4CPU = 1'b1;
    @(negedge clk);
    check("simul_head", data2CPU, {24'h0, sb_q[0]});
    @(posedge clk);
    #1;
    kbd_valid = 1'b0; re4CPU = 1'b0; addr4CPU = '0;
    void'(sb_q.pop_front());
    sb_q.push_back(8'hBB);
    $display("kbd push+pop code=bb depth=%0d", sb_q.size());
    status_chk("status_simul", 32'h0000_0802);
    for (int i = 0; i < DEPTH; i++) kbd_read("drain", c);
    check("drain_last_bb", 32'(c), 32'hBB);

    // Interrupt enable, pop clears irq, flush beats push
    cpu_wr(A_CTRL, 32'h1);
    check("irq_empty", 32'(kbd_irq), 32'h0);
    kbd_push(8'h5A);
    check("irq_after_push", 32'(kbd_irq), 32'h1);
    kbd_read("irq_pop", c);
    check("irq_after_pop", 32'(kbd_irq), 32'h0);
    kbd_push(8'h66);
    addr4CPU = A_CTRL; we4CPU = 1'b1; data4CPU = 32'h3;
    kbd_valid = 1'b1; kbd_code = 8'h77;
    @(posedge clk);
    #1;
    we4CPU = 1'b0; kbd_valid = 1'b0; addr4CPU = '0;
    sb_q.delete();
    $display("wr  addr=%08h data=%08h with kbd push 77", A_CTRL, 32'h3);
    check("irq_after_flush", 32'(kbd_irq), 32'h0);
    status_chk("status_flush", 32'h0000_0001);

    // Overflow clear loses to an overflowing push in the same cycle
    for (int i = 0; i < DEPTH; i++) kbd_push(8'(8'h80 + i));
    addr4CPU = A_CTRL; we4CPU = 1'b1; data4CPU = 32'h5;
    kbd_valid = 1'b1; kbd_code = 8'hCC;
    @(posedge clk);
    #1;
    we4CPU = 1'b0; kbd_valid = 1'b0; addr4CPU = '0;
    m_ovf = 1'b1;
    $display("wr  addr=%08h data=%08h with kbd push cc", A_CTRL, 32'h5);
    status_chk("status_ovf_race", 32'h0000_0806);
    cpu_wr(A_CTRL, 32'h2);
    sb_q.delete();
    status_chk("status_flush_keeps_ovf", 32'h0000_0005);
    cpu_wr(A_CTRL, 32'h4);
    m_ovf = 1'b0;
    cpu_wr(A_STATUS, 32'hFFFF_FFFF);
    status_chk("status_ro_write", 32'h0000_0001);
    cpu_rd(A_CTRL, d);
    check("ctrl_readback", d, 32'h0);

    // Output registers
    cpu_wr(A_OUT0 + 32'd12, 32'hDEAD_BEEF);
    m_out[3] = 32'hDEAD_BEEF;
    check("out3_port", out_regs[127:96], 32'hDEAD_BEEF);
    cpu_rd(A_OUT0 + 32'd12, d);
    check("out3_read", d, 32'hDEAD_BEEF);
    cpu_wr(A_OUT0 + 32'd4, 32'h0000_5555);
    m_out[1] = 32'h0000_5555;
    cpu_wr(A_OUT0 + 32'(4 * NUM_OUT), 32'h1234_5678);
    cpu_rd(A_OUT0 + 32'(4 * NUM_OUT), d);
    check("out_oob_read", d, 32'h0);
    for (int i = 0; i < NUM_OUT; i++) check("out_bank", out_regs[32*i +: 32], m_out[i]);
    cpu_rd(32'hF000_0010, d);
    check("dev_hole_read", d, 32'h0);

    // Unmapped region
    addr4CPU = 32'h3000_0000; re4CPU = 1'b1; we4CPU = 1'b1; data4CPU = 32'hFFFF;
    #1;
    check("unmapped_data", data2CPU, 32'h0);
    check("unmapped_strobes", {29'h0, re2Cache, we2Cache, we2VRAM}, 32'h0);
    re4CPU = 1'b0; we4CPU = 1'b0; addr4CPU = '0;
    @(posedge clk);
    #1;

    // Switch synchroniser latency
    switch = 16'h00A5;
    addr4CPU = A_SWITCH;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("switch_sync", data2CPU, (k < 3) ? 32'h0 : 32'h0000_00A5);
      $display("rd  addr=%08h data=%08h edge=%0d", A_SWITCH, data2CPU, k);
      @(posedge clk);
    end
    #1;

    // VRAM, cache and ROM pass-through
    addr4CPU = 32'h1000_0010; we4CPU = 1'b1; data4CPU = 32'h0000_0ABC;
    #1;
    check("vram_we", 32'(we2VRAM), 32'h1);
    check("vram_addr", 32'(addr2VRAM), 32'h4);
    check("vram_wdata", 32'(data2VRAM), 32'hABC);
    check("vram_no_cache_we", 32'(we2Cache), 32'h0);
    check("vram_rdata", data2CPU, 32'h0000_05A5);
    we4CPU = 1'b0;
    @(posedge clk);
    #1;
    addr4CPU = 32'h0000_0100; re4CPU = 1'b1;
    #1;
    check("cache_re", 32'(re2Cache), 32'h1);
    check("cache_rdata", data2CPU, 32'hCAFE_0001);
    check("cache_addr", addr2Cache, 32'h0000_0100);
    re4CPU = 1'b0;
    addr4CPU = 32'h2000_0008;
    #1;
    check("rom_rdata", data2CPU, 32'h0BAD_F00D);
    check("rom_addr", addr2ROM, 32'h2000_0008);
    addr4CPU = '0;
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
